// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for the N-bit shift-add multiplier: load, N add/shift steps, done handshake.
// Optional build macro SIGNED_MULT_EN enables the two's-complement final-step Cm output.
`timescale 1ns/1ps

module shift_add_mult_ctrl #(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Start,
    input  logic          M,
    output logic          Load,
    output logic          Rshift,
    output logic          AddRshift,
    output logic          Cm,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        Load      = 1'b0;
        Rshift    = 1'b0;
        AddRshift = 1'b0;
        Cm        = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (Start) state_d = S_LOAD;
            end
            S_LOAD: begin
                Load    = 1'b1;
                Busy    = 1'b1;
                count_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                Busy      = 1'b1;
                AddRshift = M;
                Rshift    = ~M;
                if (count_q == LAST) begin
                    count_d = '0;
                    state_d = S_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            S_DONE: begin
                Done    = 1'b1;
                count_d = '0;
                if (!Start) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
        // Sign-bit weight is negative: subtract the multiplicand on the last step.
`ifdef SIGNED_MULT_EN
        Cm = AddRshift && (count_q == LAST);
`else
        Cm = 1'b0;
`endif
    end

    assign Count = count_q;

    a_excl:   assert property (@(posedge CLK) disable iff (Reset)
                  $onehot0({Load, Rshift, AddRshift, Done}));
    a_cm:     assert property (@(posedge CLK) disable iff (Reset) Cm |-> AddRshift);
    a_run:    assert property (@(posedge CLK) disable iff (Reset)
                  (state_q == S_RUN) |-> (Rshift ^ AddRshift));
    a_count:  assert property (@(posedge CLK) disable iff (Reset) count_q <= LAST);

endmodule
